// File: rtl/stable_matching_seq.sv
// stable_matching_seq: sequential Gale-Shapley matcher (S proposers, R reviewers), one proposal per clock.
// Optional build macro SM_TIMEOUT_EN adds a MAX_ITER proposal limit that ends the run with timeout=1.
module stable_matching_seq #(
  parameter int S        = 4,
  parameter int R        = 4,
  parameter int Ks       = 4,
  parameter int Kr       = 4,
  parameter int MAX_ITER = S * Ks,
  localparam int LOG_S   = (S > 1) ? $clog2(S) : 1,
  localparam int LOG_R   = (R > 1) ? $clog2(R) : 1,
  localparam int GW      = S * Ks * LOG_R + R * Kr * LOG_S
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [GW-1:0]        g,
  output logic                 busy,
  output logic                 done,
  output logic [R*LOG_S-1:0]   match_list,
  output logic [R-1:0]         r_matched,
  output logic                 timeout
);

  localparam int PW   = $clog2(Ks + 1);
  localparam int KRW  = (Kr > 1) ? $clog2(Kr) : 1;
  localparam int SOFS = S * Ks * LOG_R;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PROPOSE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [GW-1:0]        pref_r;
  logic [PW-1:0]        ptr_r [S];
  logic [S-1:0]         free_r;
  logic [R*LOG_S-1:0]   match_r;
  logic [R-1:0]         matched_r;
  logic                 busy_r, done_r;

  logic                 found_s, limit_s, do_prop_s, start_ok_s;
  logic [LOG_S-1:0]     prop_s, owner_s;
  logic [PW-1:0]        cur_ptr_s;
  int                   pidx_s;
  logic [LOG_R-1:0]     tgt_s, tgt_idx_s;
  logic                 tgt_ok_s, held_s, accept_s;
  logic [KRW:0]         prank_s, crank_s;

  // Rank of proposer p in reviewer r's list as {present, rank}; the first occurrence wins.
  function automatic logic [KRW:0] rank_lookup(input logic [GW-1:0] pv, input int r,
                                               input logic [LOG_S-1:0] p);
    logic [KRW:0] res;
    res = '0;
    for (int k = Kr - 1; k >= 0; k--) begin
      if (pv[SOFS + (r * Kr + k) * LOG_S +: LOG_S] == p) res = {1'b1, KRW'(k)};
      else res = res;
    end
    return res;
  endfunction

  // Lowest-index free proposer that still has list entries left.
  always_comb begin
    found_s = 1'b0;
    prop_s  = '0;
    for (int s = S - 1; s >= 0; s--) begin
      found_s = found_s | (free_r[s] & (ptr_r[s] < PW'(Ks)));
      prop_s  = (free_r[s] && (ptr_r[s] < PW'(Ks))) ? LOG_S'(s) : prop_s;
    end
  end

  assign cur_ptr_s = ptr_r[prop_s];
  assign pidx_s    = found_s ? (int'(prop_s) * Ks + int'(cur_ptr_s)) * LOG_R : 0;
  assign tgt_s     = pref_r[pidx_s +: LOG_R];
  assign tgt_ok_s  = (int'(tgt_s) < R);
  assign tgt_idx_s = tgt_ok_s ? tgt_s : '0;
  assign owner_s   = match_r[int'(tgt_idx_s) * LOG_S +: LOG_S];
  assign held_s    = matched_r[tgt_idx_s];
  assign prank_s   = rank_lookup(pref_r, int'(tgt_idx_s), prop_s);
  assign crank_s   = rank_lookup(pref_r, int'(tgt_idx_s), owner_s);
  // Out-of-range reviewer or proposer missing from the reviewer's list is a rejection.
  assign accept_s  = tgt_ok_s && prank_s[KRW] &&
                     (!held_s || (prank_s[KRW-1:0] < crank_s[KRW-1:0]));

  assign start_ok_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign do_prop_s  = (state_r == PROPOSE) && found_s && !limit_s;

`ifdef SM_TIMEOUT_EN
  localparam int CW = (MAX_ITER > 0) ? $clog2(MAX_ITER + 1) : 1;
  logic [CW-1:0] cnt_r;
  logic          timeout_r;

  assign limit_s = (cnt_r == CW'(MAX_ITER));
  assign timeout = timeout_r;

  // Proposal counter; a run cut short with proposers still pending reports timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else if (start_ok_s) begin
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else if (do_prop_s) begin
      cnt_r <= cnt_r + CW'(1);
    end else if (state_r == PROPOSE) begin
      timeout_r <= found_s;
    end
  end
`else
  logic unused_limit_s;
  assign unused_limit_s = (MAX_ITER != 0);
  assign limit_s        = 1'b0;
  assign timeout        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) state_s = LOAD;
        else       state_s = state_r;
      end
      LOAD:    state_s = PROPOSE;
      PROPOSE: begin
        if (do_prop_s) state_s = PROPOSE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Run datapath: latch preferences on start, apply one proposal per PROPOSE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pref_r    <= '0;
      free_r    <= '0;
      match_r   <= '0;
      matched_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      for (int s = 0; s < S; s++) ptr_r[s] <= '0;
    end else if (start_ok_s) begin
      pref_r    <= g;
      free_r    <= '1;
      match_r   <= '0;
      matched_r <= '0;
      busy_r    <= 1'b1;
      done_r    <= 1'b0;
      for (int s = 0; s < S; s++) ptr_r[s] <= '0;
    end else if (do_prop_s) begin
      ptr_r[prop_s] <= cur_ptr_s + PW'(1);
      if (accept_s) begin
        match_r[int'(tgt_idx_s) * LOG_S +: LOG_S] <= prop_s;
        matched_r[tgt_idx_s] <= 1'b1;
        free_r[prop_s]       <= 1'b0;
        // The displaced partner re-enters the pool and resumes from its own pointer.
        if (held_s) free_r[owner_s] <= 1'b1;
      end
    end else if (state_r == PROPOSE) begin
      busy_r <= 1'b0;
      done_r <= 1'b1;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign match_list = match_r;
  assign r_matched  = matched_r;

endmodule

// File: tb/tb_stable_matching_seq.sv
// Randomised self-checking bench for stable_matching_seq against a reference Gale-Shapley model.
// Build with SM_TIMEOUT_EN to exercise the MAX_ITER=5 limit.
module tb_stable_matching_seq;

  localparam int S  = 4;
  localparam int R  = 4;
  localparam int Ks = 4;
  localparam int Kr = 4;
`ifdef SM_TIMEOUT_EN
  localparam int MI     = 5;
  localparam bit LIM_EN = 1'b1;
`else
  localparam int MI     = S * Ks;
  localparam bit LIM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] g = '0;
  logic        busy, done, timeout;
  logic [7:0]  match_list;
  logic [3:0]  r_matched;

  int checks = 0;
  int failures = 0;

  int sp [4][4];
  int rp [4][4];
  int exp_owner [4];
  bit exp_m [4];
  int exp_p;
  bit exp_to;

  stable_matching_seq #(.S(S), .R(R), .Ks(Ks), .Kr(Kr), .MAX_ITER(MI)) dut (
    .clk(clk), .rst(rst), .start(start), .g(g), .busy(busy), .done(done),
    .match_list(match_list), .r_matched(r_matched), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rank_of(int r, int p);
    for (int k = 0; k < Kr; k++) if (rp[r][k] == p) return k;
    return Kr;
  endfunction

  // Reference Gale-Shapley: lowest free proposer with entries left proposes next.
  task automatic model();
    int nxt [4];
    bit fr [4];
    int p, r;
    exp_p = 0;
    exp_to = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt[i] = 0; fr[i] = 1'b1; exp_owner[i] = 0; exp_m[i] = 1'b0;
    end
    while (1) begin
      p = -1;
      for (int i = S - 1; i >= 0; i--) if (fr[i] && nxt[i] < Ks) p = i;
      if (p < 0) break;
      if (LIM_EN && exp_p == MI) begin
        exp_to = 1'b1;
        break;
      end
      r = sp[p][nxt[p]];
      nxt[p]++;
      exp_p++;
      if (r >= R || rank_of(r, p) == Kr) continue;
      if (!exp_m[r]) begin
        exp_m[r] = 1'b1; exp_owner[r] = p; fr[p] = 1'b0;
      end else if (rank_of(r, p) < rank_of(r, exp_owner[r])) begin
        fr[exp_owner[r]] = 1'b1; exp_owner[r] = p; fr[p] = 1'b0;
      end
    end
  endtask

  function automatic logic [63:0] pack();
    logic [63:0] v;
    v = '0;
    for (int s = 0; s < S; s++)
      for (int k = 0; k < Ks; k++) v[(s * Ks + k) * 2 +: 2] = 2'(sp[s][k]);
    for (int r = 0; r < R; r++)
      for (int k = 0; k < Kr; k++) v[32 + (r * Kr + k) * 2 +: 2] = 2'(rp[r][k]);
    return v;
  endfunction

  task automatic set_case(input int which);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        sp[i][k] = k;
        rp[i][k] = (which == 2) ? 3 - k : k;
      end
    if (which == 6) for (int k = 0; k < 4; k++) rp[1][k] = 0;
  endtask

  task automatic set_random();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        sp[i][k] = $urandom_range(0, 3);
        rp[i][k] = $urandom_range(0, 3);
      end
  endtask

  task automatic check_result(input string tag);
    logic [7:0] eml;
    logic [3:0] erm;
    eml = '0;
    erm = '0;
    for (int r = 0; r < R; r++) begin
      erm[r] = exp_m[r];
      if (exp_m[r]) eml[r * 2 +: 2] = 2'(exp_owner[r]);
    end
    check_eq({tag, ".match_list"}, match_list, eml);
    check_eq({tag, ".r_matched"}, r_matched, erm);
    check_eq({tag, ".timeout"}, timeout, exp_to);
    check_eq({tag, ".busy"}, busy, 1'b0);
  endtask

  // One run: start pulse, scramble g, optionally retry start while busy, then check latency and result.
  task automatic run(input string tag, input bit poke);
    int n;
    model();
    @(negedge clk);
    g = pack();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    g = {$urandom, $urandom};
    check_eq({tag, ".done_low"}, done, 1'b0);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check_eq({tag, ".busy_hi"}, busy, 1'b1);
      if (poke && n == 3) start = 1'b1;
      if (poke && n == 4) start = 1'b0;
    end
    check_eq({tag, ".latency"}, n, 2 + exp_p);
    check_result(tag);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    check_eq("rst.busy", busy, 1'b0);
    check_eq("rst.done", done, 1'b0);
    check_eq("rst.match_list", match_list, 8'h00);
    check_eq("rst.r_matched", r_matched, 4'h0);
    check_eq("rst.timeout", timeout, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle.done", done, 1'b0);

    set_case(1); run("case1", 1'b0);
    set_case(2); run("case2_poke", 1'b1);
    set_case(1); run("case1_rerun", 1'b0);
    set_case(6); run("case6", 1'b0);

    // Abort mid-run after four proposals, then rerun from a clean start.
    set_case(2);
    @(negedge clk);
    g = pack();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("abort.busy", busy, 1'b0);
    check_eq("abort.done", done, 1'b0);
    check_eq("abort.r_matched", r_matched, 4'h0);
    check_eq("abort.match_list", match_list, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    run("case2_after_abort", 1'b0);

    for (int t = 0; t < 20; t++) begin
      set_random();
      run($sformatf("rand%0d", t), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
